// File: rtl/keypad_scanner.sv
// =============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with frame debounce and a 4-entry
//            valid/ready key-code FIFO.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  output logic [3:0] keypad_rows,
  input  logic [3:0] keypad_cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_TARGET  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Column synchroniser
  // ---------------------------------------------------------------------------
  logic [3:0] cols_meta;
  logic [3:0] cols_sync;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cols_meta <= '0;
      cols_sync <= '0;
    end else begin
      cols_meta <= keypad_cols;
      cols_sync <= cols_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Row scan and frame accumulation
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx;
  logic [11:0]   row_acc;
  logic          sample;
  logic          frame_done;
  logic [15:0]   frame;

  assign sample      = (dwell == DWELL_LAST);
  assign frame_done  = sample && (row_idx == 2'd3);
  // Row 3 is taken straight from the synchroniser so the frame resolves on its sample cycle.
  assign frame       = {cols_sync, row_acc};
  assign keypad_rows = 4'b0001 << row_idx;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= 2'd0;
      row_acc <= '0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
      case (row_idx)
        2'd0:    row_acc[3:0]  <= cols_sync;
        2'd1:    row_acc[7:4]  <= cols_sync;
        2'd2:    row_acc[11:8] <= cols_sync;
        default: ;
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame classification
  // ---------------------------------------------------------------------------
  logic [4:0] ones;
  logic [3:0] hit_code;
  logic       frame_none;
  logic       frame_single;

  always_comb begin
    ones     = 5'd0;
    hit_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        ones     = ones + 5'd1;
        hit_code = 4'(i);
      end
    end
  end

  assign frame_none   = (ones == 5'd0);
  assign frame_single = (ones == 5'd1);

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_n;
  logic [3:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] cnt_inc;
  logic       push;
  logic [3:0] push_code;

  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    push      = 1'b0;
    push_code = cand;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (frame_single) begin
            if (DEBOUNCE == 1) begin
              push      = 1'b1;
              push_code = hit_code;
              state_n   = ST_HELD;
            end else begin
              cand_n  = hit_code;
              cnt_n   = 4'd1;
              state_n = ST_CAND;
            end
          end
        end
        ST_CAND: begin
          if (frame_single && (hit_code == cand)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              push    = 1'b1;
              state_n = ST_HELD;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_HELD: begin
          // Extra keys while held are ignored; only a clean release leaves HELD.
          if (frame_none) begin
            if (DEBOUNCE == 1) begin
              state_n = ST_IDLE;
            end else begin
              cnt_n   = 4'd1;
              state_n = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_HELD;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       pop;
  logic       push_ok;

  assign key_valid = (count != 3'd0);
  assign pop       = key_valid && key_ready;
  assign push_ok   = push && ((count != 3'd4) || pop);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 4'd0;
      end
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
      key_code <= 4'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      // key_code is a registered copy of the head so it holds its value once drained.
      if (pop) begin
        if (count >= 3'd2) begin
          key_code <= mem[rd_ptr + 2'd1];
        end else if (push_ok) begin
          key_code <= push_code;
        end
      end else if (push_ok && (count == 3'd0)) begin
        key_code <= push_code;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// =============================================================================
// Module   : tb_keypad_scanner
// Brief    : Scoreboard bench for keypad_scanner with a row-aware keypad model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_scanner;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b1;
  logic [3:0]  keypad_rows;
  logic [3:0]  keypad_cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed = 16'h0000;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q [$];

  always #5 clk_in = ~clk_in;

  keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .keypad_rows (keypad_rows),
    .keypad_cols (keypad_cols),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .overflow    (overflow)
  );

  // A pressed key connects its row drive to its column sense.
  always_comb begin
    keypad_cols = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keypad_rows[r] && pressed[4*r+c]) keypad_cols[c] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (16 * n) @(negedge clk_in);
  endtask

  // Monitor: every accepted handshake is checked against the scoreboard.
  always begin
    logic [3:0] e;
    @(negedge clk_in);
    #2;
    if (!rst && key_valid === 1'b1 && key_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0d expected=none", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL pop_code actual=%0d expected=%0d", key_code, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then an asynchronous reset in the middle of a frame.
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (37) @(negedge clk_in);
    #1 rst = 1'b1;
    #1;
    chk("rst_rows", keypad_rows, 4'b0001);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_code", key_code, 0);
    @(negedge clk_in);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("row_scan", keypad_rows, 32'(4'b0001 << (k / 4)));
      @(negedge clk_in);
    end

    // Single press row1/col2.
    key_ready = 1'b1;
    pressed = 16'h1 << 6;
    exp_q.push_back(4'd6);
    frames(5);
    chk("single_held", key_held, 1);
    chk("single_q_empty", exp_q.size(), 0);
    pressed = 16'h0;
    frames(2);
    chk("single_held_mid_release", key_held, 1);
    frames(1);
    chk("single_released", key_held, 0);

    // Bounce rejection on row2/col0.
    pressed = 16'h1 << 8;
    frames(2);
    pressed = 16'h0;
    frames(1);
    chk("bounce_held_a", key_held, 0);
    pressed = 16'h1 << 8;
    frames(2);
    pressed = 16'h0;
    frames(3);
    chk("bounce_held_b", key_held, 0);
    chk("bounce_valid", key_valid, 0);

    // Ghost rejection, then the remaining single key is accepted.
    pressed = (16'h1 << 0) | (16'h1 << 15);
    frames(5);
    chk("ghost_held", key_held, 0);
    chk("ghost_valid", key_valid, 0);
    pressed = 16'h1 << 0;
    exp_q.push_back(4'd0);
    frames(4);
    chk("ghost_single_held", key_held, 1);
    pressed = 16'h0;
    frames(3);
    chk("ghost_released", key_held, 0);
    chk("ghost_q_empty", exp_q.size(), 0);

    // FIFO full and overflow.
    key_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      pressed = 16'h1 << c;
      if (c <= 4) exp_q.push_back(4'(c));
      frames(3);
      pressed = 16'h0;
      frames(3);
      if (c == 4) chk("ovf_before_fifth", overflow, 0);
    end
    chk("ovf_after_fifth", overflow, 1);
    chk("full_valid", key_valid, 1);
    chk("full_head", key_code, 1);
    key_ready = 1'b1;
    frames(1);
    chk("drained_valid", key_valid, 0);
    chk("drained_q_empty", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // Release bounce on code 9.
    pressed = 16'h1 << 9;
    exp_q.push_back(4'd9);
    frames(4);
    chk("rb_held", key_held, 1);
    pressed = 16'h0;
    frames(2);
    chk("rb_held_release", key_held, 1);
    pressed = 16'h1 << 9;
    frames(2);
    chk("rb_held_repress", key_held, 1);
    pressed = 16'h0;
    frames(3);
    chk("rb_released", key_held, 0);
    chk("rb_q_empty", exp_q.size(), 0);

    // Reset with a key waiting in the FIFO.
    key_ready = 1'b0;
    pressed = 16'h1 << 7;
    frames(4);
    chk("pre_rst_valid", key_valid, 1);
    chk("pre_rst_code", key_code, 7);
    chk("pre_rst_held", key_held, 1);
    #3 rst = 1'b1;
    #1;
    chk("rst2_valid", key_valid, 0);
    chk("rst2_code", key_code, 0);
    chk("rst2_held", key_held, 0);
    chk("rst2_overflow", overflow, 0);
    chk("rst2_rows", keypad_rows, 4'b0001);
    @(negedge clk_in);
    rst = 1'b0;
    pressed = 16'h0;
    repeat (4) @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses, and delivers one 4-bit key code per debounced press through a small FIFO with a valid/ready handshake. It drives the keypad row pins one at a time and samples the column pins. It sits between the board keypad pins and any consumer logic (CPU I/O register, LED display). It replaces ad-hoc per-design row/column decode with a reusable, clock-accurate controller.

## Interface
Parameters:
- SCAN_DIV, 1000: clk_in cycles each row is driven (dwell). Legal range is 4 or more.
- DEBOUNCE, 4: consecutive identical full scan frames required to accept a press or a release. Legal range is 1 to 15.

Ports:
- clk_in  input  1  system clock. Single clock domain.
- rst  input  1  reset. Asynchronous and active-high.
- keypad_rows  output  4  one-hot row drive, active-high. Bit r drives row r.
- keypad_cols  input  4  raw column sense, active-high, asynchronous to clk_in.
- key_code  output  4  code of the FIFO head, equal to 4*row + col.
- key_valid  output  1  FIFO not empty. key_code is valid while this is high.
- key_ready  input  1  consumer accepts the head on a cycle where key_valid and key_ready are both high.
- key_held  output  1  a debounced key is currently down (states HELD and RELEASE).
- overflow  output  1  sticky flag. Set when a press is dropped because the FIFO is full. Cleared only by rst.

## Operation
- **Input synchronisation:** keypad_cols passes through a 2-flop synchronizer before any use.
- **Row scan:**
  - A dwell counter runs 0..SCAN_DIV-1 and a row index runs 0..3. keypad_rows = 1 << row_idx.
  - When the dwell counter reaches SCAN_DIV-1, the synchronized columns are sampled for the current row, the counter wraps to 0, and row_idx increments (3 wraps to 0).
- **Frame evaluation:**
  - The sample taken for row 3 completes a frame and raises an internal frame_done pulse for one cycle.
  - The frame result is NONE (0 bits set across all rows), SINGLE(code) (exactly 1 bit set), or MULTI (2 or more bits set).
- **Debounce FSM** (advances only on frame_done; cnt is 4 bits):
  - IDLE: on SINGLE(c), set cand=c, cnt=1, go CAND. If DEBOUNCE==1, push c and go HELD directly. NONE and MULTI stay in IDLE.
  - CAND: on SINGLE(cand), cnt+1. When cnt reaches DEBOUNCE, push cand and go HELD. Any other result goes to IDLE.
  - HELD: on NONE, set cnt=1 and go RELEASE (if DEBOUNCE==1, go IDLE). SINGLE and MULTI stay in HELD. A second key added while one is held is never reported.
  - RELEASE: on NONE, cnt+1. When cnt reaches DEBOUNCE, go IDLE. Any press goes back to HELD with no new push.
- **FIFO:**
  - Depth 4, with 2-bit read and write pointers plus a 3-bit count.
  - Pop occurs when key_valid && key_ready.
  - A push while full drops the code and sets overflow. A push and a pop in the same cycle while full both succeed, and overflow stays unchanged.
  - A push and a pop in the same cycle while empty is impossible, because key_valid is low.
  - A push and a pop in the same cycle otherwise leaves the count unchanged.
  - key_code = mem[rd_ptr]. key_code holds its last value when the FIFO is empty, and it is 0 after reset.

## Timing
- **Reset values:** keypad_rows=4'b0001, key_code=0, key_valid=0, key_held=0, overflow=0, FSM=IDLE, all counters 0, FIFO empty.
- **Reset mid-operation:** asserting rst mid-scan or mid-debounce aborts immediately to the reset values. Any FIFO contents are lost.
- **Frame period:** 4*SCAN_DIV cycles.
- **Column setup:** a column change must reach keypad_cols at least 3 cycles before the sample cycle to be captured in that dwell.
- **Push latency:** the push happens on the frame_done cycle of the DEBOUNCE-th matching frame. key_valid rises the following cycle (registered, no fall-through).
- **key_held:** rises in the cycle after the push, and falls in the cycle after the final release frame.
- **Handshake:** key_code and key_valid change only on a pop or a push. If the head has not been accepted, it stays stable.
- **Rows and cols:** keypad_rows changes on the cycle after each sample. The consumer may hold key_ready low indefinitely; scanning continues regardless.

## Test plan
Run all scenarios with SCAN_DIV=4 and DEBOUNCE=3.

- **Reset:** assert rst mid-frame → all outputs at their reset values immediately (asynchronous). After release, keypad_rows cycles 0001, 0010, 0100, 1000, with each value held for 4 cycles.
- **Single press:** press row1/col2, answering only when keypad_rows[1]=1, and hold for 5 frames with key_ready=1 → exactly one key_code=6 with a 1-cycle key_valid, 1 cycle after the 3rd frame_done. key_held=1. Release for 3 frames → key_held=0.
- **Bounce rejection:** press row2/col0 for 2 frames, release 1 frame, press 2 frames, release → no key_valid, key_held stays 0.
- **Ghost rejection:** row0/col0 and row3/col3 pressed together for 5 frames → no push. Then release row3/col3 only → code 0 pushed 3 frames later.
- **FIFO full and overflow:** key_ready=0. Perform 5 separate debounced presses with codes 1, 2, 3, 4, 5 → overflow=1 after the 5th. Then set key_ready=1 → pops yield 1, 2, 3, 4, and key_valid then falls. overflow stays 1 until rst.
- **Release bounce:** hold code 9, release for 2 frames, re-press → key_held remains 1 and no second push occurs.
